// File: rtl/pipelined_sp_ram.sv
// rtl/pipelined_sp_ram.sv - parametrised single-port RAM with request port, clear engine and optional output register
module pipelined_sp_ram #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int OUT_REG        = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   ram [DEPTH];
    logic                    accept;
    logic                    respond;
    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;

    // The request port is simply closed while the sweep owns the array.
    assign req_ready = (state == ST_RUN);
    assign busy      = (state == ST_CLEAR);
    assign accept    = req_valid && req_ready;

    // Writes in no-change mode are the only accepted requests without a response.
    assign respond   = accept && !(req_we && (WRITE_MODE == 2));

    // Control FSM: RUN serves requests, CLEAR walks cnt over every address exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (clear_start) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Array write port, shared by the clear sweep and accepted writes; never reset.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            ram[cnt] <= '0;
        end else if (accept && req_we) begin
            ram[req_addr] <= req_wdata;
        end
    end

    // First response stage: the synchronous array read, or the write data in write-first mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= respond;
            if (respond) begin
                s1_data <= (req_we && (WRITE_MODE == 1)) ? req_wdata : ram[req_addr];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            // Optional output register; data only moves with a valid response so it holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_valid = s2_valid;
            assign rd_data  = s2_data;
        end else begin : g_no_out_reg
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_sp_ram.sv
// tb/tb_pipelined_sp_ram.sv - directed self-checking bench for pipelined_sp_ram
module tb_pipelined_sp_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [5:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       clear_start = 1'b0;

    // a: read-first, latency 2; b: write-first, latency 1; c: no-change, latency 2
    logic       rdy_a, busy_a, rv_a;
    logic [7:0] rd_a;
    logic       rdy_b, busy_b, rv_b;
    logic [7:0] rd_b;
    logic       rdy_c, busy_c, rv_c;
    logic [7:0] rd_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_sp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .OUT_REG(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .clear_start(clear_start), .busy(busy_a),
        .rd_valid(rv_a), .rd_data(rd_a)
    );

    pipelined_sp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .OUT_REG(0), .WRITE_MODE(1), .CLEAR_ON_RESET(1)) dut_wf (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .clear_start(clear_start), .busy(busy_b),
        .rd_valid(rv_b), .rd_data(rd_b)
    );

    pipelined_sp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .OUT_REG(1), .WRITE_MODE(2), .CLEAR_ON_RESET(1)) dut_nc (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_c), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .clear_start(clear_start), .busy(busy_c),
        .rd_valid(rv_c), .rd_data(rd_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [5:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        step();
        step();
    endtask

    task automatic single_read(input logic [5:0] a, input logic [7:0] exp, input string nm);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        step();
        req_valid = 1'b0;
        total++; if (rv_b !== 1'b1 || rd_b !== exp) begin bad++; $display("FAIL %s_wf_lat1: valid=%b data=%h want valid=1 data=%h", nm, rv_b, rd_b, exp); end
        total++; if (rv_a !== 1'b0 || rv_c !== 1'b0) begin bad++; $display("FAIL %s_early: a=%b c=%b want 0 0", nm, rv_a, rv_c); end
        step();
        total++; if (rv_a !== 1'b1 || rd_a !== exp) begin bad++; $display("FAIL %s_rf_lat2: valid=%b data=%h want valid=1 data=%h", nm, rv_a, rd_a, exp); end
        total++; if (rv_c !== 1'b1 || rd_c !== exp) begin bad++; $display("FAIL %s_nc_lat2: valid=%b data=%h want valid=1 data=%h", nm, rv_c, rd_c, exp); end
        total++; if (rv_b !== 1'b0) begin bad++; $display("FAIL %s_wf_pulse: valid=%b want 0", nm, rv_b); end
    endtask

    // Steps until busy falls; counts steps and any cycle where a busy DUT looks open or responds.
    task automatic run_sweep(input int restart_at, output int n, output int leaks);
        n = 0;
        leaks = 0;
        while (busy_a && n < 200) begin
            clear_start = (n == restart_at);
            step();
            n++;
            if (busy_a && (rdy_a || rdy_b || rdy_c || !busy_b || !busy_c || rv_a || rv_b || rv_c)) leaks++;
        end
        clear_start = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (rv_a !== 1'b0 || rv_b !== 1'b0 || rv_c !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: %b%b%b want 000", rv_a, rv_b, rv_c); end
        total++; if (rd_a !== 8'h00 || rd_b !== 8'h00 || rd_c !== 8'h00) begin bad++; $display("FAIL reset_rd_data: %h %h %h want 00", rd_a, rd_b, rd_c); end
        total++; if (busy_a !== 1'b1 || busy_b !== 1'b1 || busy_c !== 1'b1) begin bad++; $display("FAIL reset_busy: %b%b%b want 111", busy_a, busy_b, busy_c); end
        total++; if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || rdy_c !== 1'b0) begin bad++; $display("FAIL reset_ready: %b%b%b want 000", rdy_a, rdy_b, rdy_c); end
    endtask

    task automatic test_clear_sweep();
        int n, leaks;
        rst = 1'b0;
        run_sweep(-1, n, leaks);
        total++; if (n !== 64) begin bad++; $display("FAIL sweep_len: got %0d want 64", n); end
        total++; if (leaks !== 0) begin bad++; $display("FAIL sweep_closed: got %0d bad cycles want 0", leaks); end
        total++; if (rdy_a !== 1'b1 || busy_b !== 1'b0) begin bad++; $display("FAIL sweep_run: ready=%b busy_b=%b want 1 0", rdy_a, busy_b); end
        for (int i = 0; i < 64; i++) single_read(6'(i), 8'h00, "cleared");
    endtask

    task automatic test_latency();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd5; req_wdata = 8'hA5;
        step();
        total++; if (rv_b !== 1'b1 || rd_b !== 8'hA5) begin bad++; $display("FAIL lat_wf_wresp: valid=%b data=%h want 1 a5", rv_b, rd_b); end
        total++; if (rv_a !== 1'b0 || rv_c !== 1'b0) begin bad++; $display("FAIL lat_w_early: a=%b c=%b want 0 0", rv_a, rv_c); end
        req_we = 1'b0;
        step();
        req_valid = 1'b0;
        total++; if (rv_b !== 1'b1 || rd_b !== 8'hA5) begin bad++; $display("FAIL lat_wf_rresp: valid=%b data=%h want 1 a5", rv_b, rd_b); end
        total++; if (rv_a !== 1'b1 || rd_a !== 8'h00) begin bad++; $display("FAIL lat_rf_wresp_old: valid=%b data=%h want 1 00", rv_a, rd_a); end
        total++; if (rv_c !== 1'b0) begin bad++; $display("FAIL lat_nc_no_wresp: valid=%b want 0", rv_c); end
        step();
        total++; if (rv_a !== 1'b1 || rd_a !== 8'hA5) begin bad++; $display("FAIL lat_rf_rresp: valid=%b data=%h want 1 a5", rv_a, rd_a); end
        total++; if (rv_c !== 1'b1 || rd_c !== 8'hA5) begin bad++; $display("FAIL lat_nc_rresp: valid=%b data=%h want 1 a5", rv_c, rd_c); end
        total++; if (rv_b !== 1'b0 || rd_b !== 8'hA5) begin bad++; $display("FAIL lat_wf_hold: valid=%b data=%h want 0 a5", rv_b, rd_b); end
        step();
        total++; if (rv_a !== 1'b0 || rd_a !== 8'hA5) begin bad++; $display("FAIL lat_rf_hold: valid=%b data=%h want 0 a5", rv_a, rd_a); end
    endtask

    task automatic test_write_modes();
        write_word(6'd3, 8'h11);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd3; req_wdata = 8'h22;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        total++; if (rv_b !== 1'b1 || rd_b !== 8'h22) begin bad++; $display("FAIL wm1_resp: valid=%b data=%h want 1 22", rv_b, rd_b); end
        total++; if (rv_c !== 1'b0) begin bad++; $display("FAIL wm2_none1: valid=%b want 0", rv_c); end
        step();
        total++; if (rv_a !== 1'b1 || rd_a !== 8'h11) begin bad++; $display("FAIL wm0_resp: valid=%b data=%h want 1 11", rv_a, rd_a); end
        total++; if (rv_c !== 1'b0 || rd_c !== 8'hA5) begin bad++; $display("FAIL wm2_none2: valid=%b data=%h want 0 a5", rv_c, rd_c); end
        step();
        single_read(6'd3, 8'h22, "wm_after");
    endtask

    task automatic test_streaming();
        logic       ev;
        logic [7:0] ed;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 6'(i); req_wdata = 8'(i);
            step();
        end
        req_valid = 1'b0; req_we = 1'b0;
        step();
        step();
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 10); req_addr = 6'(c);
            step();
            ev = (c < 10); ed = 8'(c);
            total++; if (rv_b !== ev || (ev && rd_b !== ed)) begin bad++; $display("FAIL stream_wf c=%0d: valid=%b data=%h want %b %h", c, rv_b, rd_b, ev, ed); end
            ev = (c >= 1 && c <= 10); ed = 8'(c - 1);
            total++; if (rv_a !== ev || (ev && rd_a !== ed)) begin bad++; $display("FAIL stream_rf c=%0d: valid=%b data=%h want %b %h", c, rv_a, rd_a, ev, ed); end
            total++; if (rv_c !== ev || (ev && rd_c !== ed)) begin bad++; $display("FAIL stream_nc c=%0d: valid=%b data=%h want %b %h", c, rv_c, rd_c, ev, ed); end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_clear_collision();
        int n, leaks;
        write_word(6'd7, 8'h3C);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd7; clear_start = 1'b1;
        step();
        clear_start = 1'b0; req_addr = 6'd9;
        total++; if (busy_a !== 1'b1 || rdy_a !== 1'b0) begin bad++; $display("FAIL coll_busy: busy=%b ready=%b want 1 0", busy_a, rdy_a); end
        total++; if (rv_b !== 1'b1 || rd_b !== 8'h3C) begin bad++; $display("FAIL coll_wf_resp: valid=%b data=%h want 1 3c", rv_b, rd_b); end
        step();
        total++; if (rv_a !== 1'b1 || rd_a !== 8'h3C) begin bad++; $display("FAIL coll_rf_resp: valid=%b data=%h want 1 3c", rv_a, rd_a); end
        total++; if (rv_c !== 1'b1 || rd_c !== 8'h3C) begin bad++; $display("FAIL coll_nc_resp: valid=%b data=%h want 1 3c", rv_c, rd_c); end
        total++; if (rv_b !== 1'b0) begin bad++; $display("FAIL coll_held_not_taken: valid=%b want 0", rv_b); end
        run_sweep(10, n, leaks);
        total++; if (n + 1 !== 64) begin bad++; $display("FAIL coll_sweep_len: got %0d want 64", n + 1); end
        total++; if (leaks !== 0) begin bad++; $display("FAIL coll_sweep_closed: got %0d bad cycles want 0", leaks); end
        single_read(6'd9, 8'h00, "coll_held");
        single_read(6'd7, 8'h00, "coll_addr7");
    endtask

    task automatic test_reset_mid_sweep();
        int n, leaks;
        write_word(6'd50, 8'h77);
        write_word(6'd2, 8'h5A);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd2; clear_start = 1'b1;
        step();
        req_valid = 1'b0; clear_start = 1'b0;
        step();
        repeat (18) step();
        total++; if (rd_a !== 8'h5A || busy_a !== 1'b1) begin bad++; $display("FAIL rstmid_pre: data=%h busy=%b want 5a 1", rd_a, busy_a); end
        #1 rst = 1'b1;
        #1;
        total++; if (rv_a !== 1'b0 || rv_b !== 1'b0 || rv_c !== 1'b0) begin bad++; $display("FAIL rstmid_valid: %b%b%b want 000", rv_a, rv_b, rv_c); end
        total++; if (rd_a !== 8'h00 || rd_b !== 8'h00 || rd_c !== 8'h00) begin bad++; $display("FAIL rstmid_data: %h %h %h want 00", rd_a, rd_b, rd_c); end
        step();
        step();
        rst = 1'b0;
        run_sweep(-1, n, leaks);
        total++; if (n !== 64) begin bad++; $display("FAIL rstmid_sweep_len: got %0d want 64", n); end
        total++; if (leaks !== 0) begin bad++; $display("FAIL rstmid_sweep_closed: got %0d bad cycles want 0", leaks); end
        single_read(6'd50, 8'h00, "rstmid_addr50");
        single_read(6'd2, 8'h00, "rstmid_addr2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        test_reset();
        test_clear_sweep();
        test_latency();
        test_write_modes();
        test_streaming();
        test_clear_collision();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
